// File: rtl/brick_sort_sched_pkg.sv
// Shared types and helpers for the brick sort scheduler.
// State encoding plus width derivation used by the scheduler and arbiter.
package brick_sort_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int vec_w(input int dw, input int lg);
        return dw * (1 << lg);
    endfunction

    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/brick_sort_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first request at or after ptr, in circular order.
module rr_arbiter
    import brick_sort_sched_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any_req
);

    // Scan from ptr around the ring; first hit wins.
    always_comb begin
        logic [IW:0]   s;
        logic [IW-1:0] j;
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        s       = '0;
        j       = '0;
        for (int i = 0; i < N; i++) begin
            s = {1'b0, ptr} + (IW+1)'(i);
            if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
            j = s[IW-1:0];
            if (!any_req && req[j]) begin
                any_req  = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/brick_sort_scheduler.sv
// Shares one brick sort engine between NUM_REQ requesters, one job at a time.
// Optional SORT watchdog enabled by defining BRICK_SORT_SCHED_TIMEOUT_EN.
module brick_sort_scheduler
    import brick_sort_sched_pkg::*;
#(
    parameter int LOG_INPUT_NUM  = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int VEC_W = vec_w(DATA_WIDTH, LOG_INPUT_NUM),
    localparam int ID_W  = id_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*VEC_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [VEC_W-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic                     eng_rst,
    output logic                     eng_x_valid,
    output logic [VEC_W-1:0]         eng_x,
    input  logic [VEC_W-1:0]         eng_y,
    input  logic                     eng_y_valid,
    output logic                     busy
);

`ifdef BRICK_SORT_SCHED_TIMEOUT_EN
    localparam int CNT_W = clog2(TIMEOUT_CYCLES + 1);
`else
    // Only "past the first SORT cycle" matters without the watchdog.
    localparam int CNT_W = 1;
`endif

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    id_reg;
    logic [ID_W-1:0]    gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               any_req;
    logic               accept;
    logic [VEC_W-1:0]   in_buf;
    logic [VEC_W-1:0]   sel_data;
    logic [CNT_W-1:0]   cnt;
`ifdef BRICK_SORT_SCHED_TIMEOUT_EN
    logic               err_q;
`endif

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .grant  (gnt),
        .idx    (gnt_idx),
        .any_req(any_req)
    );

    // Handshake is only offered in IDLE and never while reset is held.
    assign accept    = (state == IDLE) && any_req && !rst;
    assign req_ready = accept ? gnt : '0;

    // One-hot grant mux selecting the winning requester's vector.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) sel_data = req_data[i*VEC_W +: VEC_W];
        end
    end

    assign rsp_valid   = (state == RESP);
    assign eng_rst     = (state != SORT);
    assign eng_x_valid = (state == SORT);
    assign eng_x       = in_buf;
    assign busy        = (state != IDLE);

`ifdef BRICK_SORT_SCHED_TIMEOUT_EN
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Job sequencing: accept, run engine, hold result until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            id_reg   <= '0;
            in_buf   <= '0;
            cnt      <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
`ifdef BRICK_SORT_SCHED_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        in_buf <= sel_data;
                        id_reg <= gnt_idx;
                        cnt    <= '0;
                        state  <= SORT;
                        rr_ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ?
                                  '0 : gnt_idx + ID_W'(1);
                    end
                end
                SORT: begin
                    if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
                    // Done status at cnt==0 may be stale from reset release.
                    if (cnt != '0 && eng_y_valid) begin
                        rsp_data <= eng_y;
                        rsp_id   <= id_reg;
                        state    <= RESP;
                    end
`ifdef BRICK_SORT_SCHED_TIMEOUT_EN
                    else if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                        rsp_data <= '0;
                        rsp_id   <= id_reg;
                        err_q    <= 1'b1;
                        state    <= RESP;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
`ifdef BRICK_SORT_SCHED_TIMEOUT_EN
                        err_q <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_brick_sort_scheduler.sv
// Self-checking bench for brick_sort_scheduler with a behavioural engine.
// Scoreboard queue holds expected responses pushed at grant time.
module tb_brick_sort_scheduler;

    localparam int DW = 32;
    localparam int VW = 256;
    localparam int NR = 4;

    typedef struct {
        logic [1:0]    id;
        logic [VW-1:0] data;
        logic          err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*VW-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [1:0]        rsp_id;
    logic [VW-1:0]     rsp_data;
    logic              rsp_err;
    logic              eng_rst;
    logic              eng_x_valid;
    logic [VW-1:0]     eng_x;
    logic [VW-1:0]     eng_y;
    logic              eng_y_valid;
    logic              busy;

    int   checks = 0;
    int   passed = 0;
    exp_t sb[$];

    int   done_at = 5;
    bit   stale = 1'b0;
    int   ecnt = 0;

    brick_sort_scheduler #(
        .LOG_INPUT_NUM (3),
        .DATA_WIDTH    (DW),
        .NUM_REQ       (NR),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .eng_rst    (eng_rst),
        .eng_x_valid(eng_x_valid),
        .eng_x      (eng_x),
        .eng_y      (eng_y),
        .eng_y_valid(eng_y_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] sort_vec(input logic [VW-1:0] v);
        logic [DW-1:0] a [8];
        logic [DW-1:0] t;
        logic [VW-1:0] r;
        for (int i = 0; i < 8; i++) a[i] = v[i*DW +: DW];
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 7; i++) begin
                if (a[i] > a[i+1]) begin
                    t = a[i]; a[i] = a[i+1]; a[i+1] = t;
                end
            end
        end
        r = '0;
        for (int i = 0; i < 8; i++) r[(7-i)*DW +: DW] = a[i];
        return r;
    endfunction

    function automatic logic [VW-1:0] mk_vec(input int seed);
        logic [VW-1:0] r;
        for (int i = 0; i < 8; i++)
            r[i*DW +: DW] = DW'(((i * 37 + seed * 11) % 97) + seed * 1000);
        return r;
    endfunction

    // Engine model: counts cycles out of reset, done at ecnt >= done_at.
    always @(posedge clk) begin
        if (eng_rst) ecnt <= 0;
        else if (ecnt < 1000000) ecnt <= ecnt + 1;
    end

    always_comb begin
        eng_y_valid = stale ? 1'b1 : (!eng_rst && ecnt >= done_at);
        eng_y = (!eng_rst && ecnt >= 1) ? sort_vec(eng_x) : {VW{1'b1}};
    end

    task automatic set_vec(input int i, input logic [VW-1:0] v);
        req_data[i*VW +: VW] = v;
    endtask

    task automatic wait_rsp(input int bound, output int k,
                            output bit ok, output int gr);
        k = 0; ok = 1'b0; gr = 0;
        while (k < bound && !ok) begin
            @(negedge clk); #1; k++;
            if (req_ready != '0) gr++;
            if (rsp_valid) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b0) $display("FAIL reset_req_ready got %b want 0000", req_ready);
        else passed++;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_flags got v=%b e=%b b=%b want 0 0 0", rsp_valid, rsp_err, busy);
        else passed++;
        checks++;
        if (rsp_id !== 2'd0 || rsp_data !== '0)
            $display("FAIL reset_rsp got id=%0d data=%h want 0", rsp_id, rsp_data);
        else passed++;
        checks++;
        if (eng_rst !== 1'b1 || eng_x_valid !== 1'b0 || eng_x !== '0)
            $display("FAIL reset_eng got rst=%b xv=%b x=%h want 1 0 0", eng_rst, eng_x_valid, eng_x);
        else passed++;
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        int   exp_order[5] = '{0, 1, 2, 3, 0};
        int   g_seen, r_seen, cyc;
        bit   drop;
        int   g;
        exp_t e;
        done_at = 2; stale = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < NR; i++) set_vec(i, mk_vec(i + 1));
        req_valid = 4'hF;
        @(negedge clk);
        rst = 1'b0;
        g_seen = 0; r_seen = 0; cyc = 0; drop = 1'b0;
        while (r_seen < 5 && cyc < 300) begin
            #1;
            if (req_ready != '0) begin
                checks++;
                if (g_seen >= 5 || req_ready !== (4'b1 << exp_order[g_seen]))
                    $display("FAIL rr_grant_%0d got %b want one-hot %0d", g_seen, req_ready,
                             exp_order[g_seen % 5]);
                else passed++;
                g = exp_order[g_seen % 5];
                sb.push_back('{id: 2'(g), data: sort_vec(mk_vec(g + 1)), err: 1'b0});
                g_seen++;
                if (g_seen == 5) drop = 1'b1;
            end
            if (rsp_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL rr_rsp_unexpected got id=%0d want none", rsp_id);
                end else begin
                    e = sb.pop_front();
                    if (rsp_id !== e.id || rsp_data !== e.data)
                        $display("FAIL rr_rsp_%0d got id=%0d data=%h want id=%0d data=%h",
                                 r_seen, rsp_id, rsp_data, e.id, e.data);
                    else passed++;
                end
                r_seen++;
            end
            @(negedge clk);
            cyc++;
            if (drop) begin req_valid = '0; drop = 1'b0; end
        end
        checks++;
        if (r_seen != 5 || g_seen != 5)
            $display("FAIL rr_count got grants=%0d rsps=%0d want 5 5", g_seen, r_seen);
        else passed++;
        rsp_ready = 1'b0;
        sb.delete();
    endtask

    task automatic test_single();
        logic [VW-1:0] v;
        logic [VW-1:0] w;
        int k, gr; bit ok;
        exp_t e;
        v = {32'd7, 32'd3, 32'd5, 32'd1, 32'd8, 32'd2, 32'd6, 32'd4};
        w = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        done_at = 5; rsp_ready = 1'b0;
        @(negedge clk);
        set_vec(2, v);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) $display("FAIL single_grant got %b want 0100", req_ready);
        else passed++;
        sb.push_back('{id: 2'd2, data: w, err: 1'b0});
        @(negedge clk);
        req_valid = '0;
        wait_rsp(50, k, ok, gr);
        e = sb.pop_front();
        checks++;
        if (!ok || k + 1 != 7) $display("FAIL single_latency got %0d want 7", ok ? k + 1 : -1);
        else passed++;
        checks++;
        if (rsp_id !== e.id || rsp_data !== e.data || rsp_err !== 1'b0)
            $display("FAIL single_rsp got id=%0d data=%h want id=%0d data=%h",
                     rsp_id, rsp_data, e.id, e.data);
        else passed++;
        checks++;
        if (gr != 0) $display("FAIL single_extra_grant got %0d want 0", gr);
        else passed++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int k, gr, ng; bit ok, stable;
        exp_t e;
        done_at = 2; rsp_ready = 1'b0;
        set_vec(1, mk_vec(9));
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) $display("FAIL bp_grant got %b want 0010", req_ready);
        else passed++;
        sb.push_back('{id: 2'd1, data: sort_vec(mk_vec(9)), err: 1'b0});
        wait_rsp(50, k, ok, gr);
        e = sb.pop_front();
        checks++;
        if (!ok || rsp_id !== e.id || rsp_data !== e.data)
            $display("FAIL bp_rsp got v=%b id=%0d data=%h want id=%0d data=%h",
                     rsp_valid, rsp_id, rsp_data, e.id, e.data);
        else passed++;
        stable = 1'b1; ng = gr;
        repeat (10) begin
            @(negedge clk); #1;
            if (!rsp_valid || rsp_id !== e.id || rsp_data !== e.data) stable = 1'b0;
            if (req_ready != '0) ng++;
        end
        checks++;
        if (!stable) $display("FAIL bp_stable got v=%b data=%h want held", rsp_valid, rsp_data);
        else passed++;
        checks++;
        if (ng != 0) $display("FAIL bp_no_grant got %0d grants want 0", ng);
        else passed++;
        rsp_ready = 1'b1;
        req_valid = '0;
        @(negedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL bp_release got v=%b busy=%b want 0 0", rsp_valid, busy);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int k, gr; bit ok;
        exp_t e;
        done_at = 1; rsp_ready = 1'b1;
        set_vec(3, mk_vec(4));
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        sb.push_back('{id: 2'd3, data: sort_vec(mk_vec(4)), err: 1'b0});
        wait_rsp(50, k, ok, gr);
        e = sb.pop_front();
        checks++;
        if (!ok || rsp_id !== e.id || rsp_data !== e.data)
            $display("FAIL b2b_rsp1 got id=%0d data=%h want id=%0d data=%h",
                     rsp_id, rsp_data, e.id, e.data);
        else passed++;
        @(negedge clk); #1;
        checks++;
        if (req_ready !== 4'b1000) $display("FAIL b2b_regrant got %b want 1000", req_ready);
        else passed++;
        sb.push_back('{id: 2'd3, data: sort_vec(mk_vec(4)), err: 1'b0});
        @(negedge clk);
        req_valid = '0;
        wait_rsp(50, k, ok, gr);
        e = sb.pop_front();
        checks++;
        if (!ok || k + 1 != 3 || rsp_data !== e.data)
            $display("FAIL b2b_rsp2 got lat=%0d data=%h want lat=3 data=%h",
                     ok ? k + 1 : -1, rsp_data, e.data);
        else passed++;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_stale();
        int k, gr; bit ok;
        exp_t e;
        stale = 1'b1; rsp_ready = 1'b0;
        set_vec(0, mk_vec(5));
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        sb.push_back('{id: 2'd0, data: sort_vec(mk_vec(5)), err: 1'b0});
        @(negedge clk);
        req_valid = '0;
        wait_rsp(50, k, ok, gr);
        e = sb.pop_front();
        checks++;
        if (!ok || k + 1 != 3) $display("FAIL stale_latency got %0d want 3", ok ? k + 1 : -1);
        else passed++;
        checks++;
        if (rsp_data !== e.data || rsp_id !== e.id)
            $display("FAIL stale_data got id=%0d data=%h want id=%0d data=%h",
                     rsp_id, rsp_data, e.id, e.data);
        else passed++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        stale = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        done_at = 20; rsp_ready = 1'b1;
        set_vec(2, mk_vec(7));
        @(negedge clk);
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || eng_rst !== 1'b1 || rsp_valid !== 1'b0 || eng_x_valid !== 1'b0)
            $display("FAIL mid_reset got busy=%b erst=%b v=%b xv=%b want 0 1 0 0",
                     busy, eng_rst, rsp_valid, eng_x_valid);
        else passed++;
        req_valid = 4'hF;
        #1;
        checks++;
        if (req_ready !== 4'b0001) $display("FAIL mid_reset_ptr got %b want 0001", req_ready);
        else passed++;
        req_valid = '0;
        seen = 0;
        repeat (30) begin
            @(negedge clk); #1;
            if (rsp_valid || busy) seen++;
        end
        checks++;
        if (seen != 0) $display("FAIL mid_reset_no_rsp got %0d active cycles want 0", seen);
        else passed++;
        rsp_ready = 1'b0;
    endtask

`ifdef BRICK_SORT_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int k, gr; bit ok;
        exp_t e;
        done_at = 1000000; rsp_ready = 1'b0;
        set_vec(1, mk_vec(3));
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        sb.push_back('{id: 2'd1, data: '0, err: 1'b1});
        @(negedge clk);
        req_valid = '0;
        wait_rsp(60, k, ok, gr);
        e = sb.pop_front();
        checks++;
        if (!ok || k + 1 != 18) $display("FAIL to_latency got %0d want 18", ok ? k + 1 : -1);
        else passed++;
        checks++;
        if (rsp_err !== e.err || rsp_data !== e.data || rsp_id !== e.id)
            $display("FAIL to_rsp got err=%b id=%0d data=%h want 1 1 0", rsp_err, rsp_id, rsp_data);
        else passed++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        done_at = 2;
        set_vec(0, mk_vec(6));
        req_valid = 4'b0001;
        #1;
        sb.push_back('{id: 2'd0, data: sort_vec(mk_vec(6)), err: 1'b0});
        @(negedge clk);
        req_valid = '0;
        wait_rsp(60, k, ok, gr);
        e = sb.pop_front();
        checks++;
        if (!ok || rsp_err !== e.err || rsp_data !== e.data)
            $display("FAIL to_next_job got err=%b data=%h want 0 %h", rsp_err, rsp_data, e.data);
        else passed++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_stale();
        test_reset_mid();
`ifdef BRICK_SORT_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
